flog_arb: RTL and testbench
===========================

FLOG_ARB -- requirements
Module: flog_arb

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one bfloat16 log unit, legal range 2..8.
REQ-002 Parameter TMO_CYC, default 64: watchdog limit in cycles, legal range 2..255.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 req_valid_i  input  N_REQ  per-requester request strobe.
REQ-006 req_data_i  input  16*N_REQ  bfloat16 operands; requester k occupies bits [16k+15:16k].
REQ-007 req_ready_o  output  N_REQ  one-hot accept; at most one bit set per cycle.
REQ-008 unit_valid_o  output  1  one-cycle start pulse to the log unit.
REQ-009 unit_data_o  output  16  operand to the log unit, stable from the start pulse until the response.
REQ-010 unit_done_i  input  1  log unit result-valid pulse.
REQ-011 unit_data_i  input  16  log unit bfloat16 result.
REQ-012 resp_valid_o  output  N_REQ  one-hot response strobe to the owning requester.
REQ-013 resp_data_o  output  16  response value.
REQ-014 resp_ready_i  input  1  consumer accepts the current response.
REQ-015 busy_o  output  1  high in every state except IDLE.
REQ-016 err_o  output  1  high together with resp_valid_o when the response is a watchdog abort.

Function
REQ-017 FSM states: IDLE, ISSUE, WAIT, RESP, 2-bit encoding 00/01/10/11.
REQ-018 IDLE: if any req_valid_i is set, grant = the first set bit at or after rr_ptr (round-robin, wrapping N_REQ-1 to 0); assert req_ready_o[grant] combinationally in the same cycle; latch operand and grant index; go to ISSUE.
REQ-019 IDLE with no request: all outputs low, stay in IDLE.
REQ-020 req_ready_o is never asserted outside IDLE; requests arriving in other states wait, and deasserted requests are dropped without penalty.
REQ-021 ISSUE: unit_valid_o=1 for exactly one cycle; go to WAIT unconditionally; unit_done_i is ignored in ISSUE.
REQ-022 WAIT: on unit_done_i, latch unit_data_i into resp_data_o and go to RESP; otherwise stay in WAIT.
REQ-023 RESP: resp_valid_o[grant]=1, held with resp_data_o stable until resp_ready_i; on that cycle set rr_ptr=grant+1 (mod N_REQ) and go to IDLE.
REQ-024 Latency: accept at cycle 0, start pulse at cycle 1, done at cycle d>=2 gives resp_valid_o at cycle d+1.
REQ-025 unit_done_i in IDLE or RESP is ignored and does not alter resp_data_o.
REQ-026 Minimum spacing between consecutive grants is 4 cycles (IDLE, ISSUE, WAIT, RESP).
REQ-027 Fairness: with all requesters continuously valid, grants cycle 0,1,...,N_REQ-1,0 in order.

Reset
REQ-028 On rst low, immediately: state IDLE, rr_ptr=0, watchdog counter=0, latched grant=0, and all outputs 0 (req_ready_o, unit_valid_o, unit_data_o, resp_valid_o, resp_data_o, busy_o, err_o).
REQ-029 Reset mid-transaction aborts it with no response issued; a late unit_done_i after reset release is ignored per REQ-025.

Configuration
REQ-030 Macro FLOG_ARB_WDOG_EN defined: an 8-bit counter clears on entry to WAIT and increments each WAIT cycle; when it reaches TMO_CYC without unit_done_i, go to RESP with resp_data_o=16'h7FC0 (qNaN) and err_o=1.
REQ-031 FLOG_ARB_WDOG_EN defined and unit_done_i in the expiry cycle: done wins, err_o=0, the result is latched.
REQ-032 FLOG_ARB_WDOG_EN undefined: no counter is present, WAIT persists indefinitely, and err_o is tied to 0.

Verification
REQ-033 Single request: req_valid_i=4'b0100 with operand 16'h4000, done at cycle 5 with 16'h3F31 -> req_ready_o=4'b0100 at cycle 0, unit_valid_o at cycle 1, resp_valid_o=4'b0100 and resp_data_o=16'h3F31 at cycle 6.
REQ-034 All four requesters held valid, instant done, resp_ready_i=1 -> grant order 0,1,2,3,0, each spaced 4 cycles.
REQ-035 Backpressure: resp_ready_i low for 10 cycles -> resp_valid_o and resp_data_o stable, req_ready_o=0 throughout, no new grant.
REQ-036 With FLOG_ARB_WDOG_EN and TMO_CYC=8, no done -> after 8 WAIT cycles resp_data_o=16'h7FC0 and err_o=1; a repeat with done in the expiry cycle -> result latched, err_o=0.
REQ-037 rst pulsed low while in WAIT, then done asserted after release -> all outputs 0, no resp_valid_o, next grant starts from requester 0.
REQ-038 Stray unit_done_i pulse in IDLE and ISSUE -> no state change and resp_data_o unchanged.

Source files
------------

// File: rtl/flog_arb.sv
// flog_arb: round-robin arbiter sharing one bfloat16 log unit among N_REQ requesters.
// One transaction at a time: IDLE (grant) -> ISSUE (start pulse) -> WAIT -> RESP.
// Optional watchdog on the WAIT state, enabled by defining FLOG_ARB_WDOG_EN; on
// expiry the requester receives a quiet NaN with err_o set.

module flog_arb #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned TMO_CYC = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid_i,
    input  logic [16*N_REQ-1:0]  req_data_i,
    output logic [N_REQ-1:0]     req_ready_o,
    output logic                 unit_valid_o,
    output logic [15:0]          unit_data_o,
    input  logic                 unit_done_i,
    input  logic [15:0]          unit_data_i,
    output logic [N_REQ-1:0]     resp_valid_o,
    output logic [15:0]          resp_data_o,
    input  logic                 resp_ready_i,
    output logic                 busy_o,
    output logic                 err_o
);

    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    // Elaboration-time parameter range checks
    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
        $error("flog_arb: N_REQ out of range 2..8");
    end
    if (TMO_CYC < 2 || TMO_CYC > 255) begin : g_bad_tmo
        $error("flog_arb: TMO_CYC out of range 2..255");
    end

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StIssue = 2'b01,
        StWait  = 2'b10,
        StResp  = 2'b11
    } state_e;

    state_e          state_q;
    logic [IW-1:0]   rr_ptr_q;
    logic [IW-1:0]   grant_q;
    logic [15:0]     op_q;
    logic [15:0]     res_q;
    logic            req_any;
    logic [IW-1:0]   pick;
    logic [IW-1:0]   next_ptr;

`ifdef FLOG_ARB_WDOG_EN
    localparam logic [15:0] QuietNan = 16'h7FC0;
    logic [7:0]      wdog_q;
    logic            err_q;
`endif

    // Round-robin search: first valid requester at or after rr_ptr_q, wrapping
    always_comb begin
        req_any = 1'b0;
        pick    = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!req_any && req_valid_i[IW'((32'(rr_ptr_q) + i) % N_REQ)]) begin
                req_any = 1'b1;
                pick    = IW'((32'(rr_ptr_q) + i) % N_REQ);
            end
        end
    end

    assign next_ptr = (grant_q == IW'(N_REQ - 1)) ? '0 : grant_q + IW'(1);

    // Combinational accept in IDLE; forced low while reset is held
    always_comb begin
        req_ready_o = '0;
        if (rst && state_q == StIdle && req_any) begin
            req_ready_o[pick] = 1'b1;
        end
    end

    // Response strobe to the owning requester
    always_comb begin
        resp_valid_o = '0;
        if (state_q == StResp) begin
            resp_valid_o[grant_q] = 1'b1;
        end
    end

    assign unit_valid_o = (state_q == StIssue);
    assign unit_data_o  = op_q;
    assign resp_data_o  = res_q;
    assign busy_o       = (state_q != StIdle);

`ifdef FLOG_ARB_WDOG_EN
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    // Transaction FSM with operand, result and round-robin pointer state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            op_q     <= '0;
            res_q    <= '0;
`ifdef FLOG_ARB_WDOG_EN
            wdog_q   <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_any) begin
                        grant_q <= pick;
                        op_q    <= req_data_i[16*pick +: 16];
                        state_q <= StIssue;
                    end
                end
                StIssue: begin
                    // A done pulse here is spurious and deliberately ignored
                    state_q <= StWait;
`ifdef FLOG_ARB_WDOG_EN
                    wdog_q  <= '0;
`endif
                end
                StWait: begin
                    if (unit_done_i) begin
                        res_q   <= unit_data_i;
                        state_q <= StResp;
                    end
`ifdef FLOG_ARB_WDOG_EN
                    // Done takes priority over expiry in the same cycle
                    else if (wdog_q == 8'(TMO_CYC - 1)) begin
                        res_q   <= QuietNan;
                        err_q   <= 1'b1;
                        state_q <= StResp;
                    end else begin
                        wdog_q  <= wdog_q + 8'd1;
                    end
`endif
                end
                StResp: begin
                    if (resp_ready_i) begin
                        rr_ptr_q <= next_ptr;
                        state_q  <= StIdle;
`ifdef FLOG_ARB_WDOG_EN
                        err_q    <= 1'b0;
`endif
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_flog_arb.sv
// Self-checking bench for flog_arb (N_REQ=4, TMO_CYC=8). Watchdog cases are
// selected by FLOG_ARB_WDOG_EN to match the DUT build.

module tb_flog_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid_i = '0;
    logic [63:0] req_data_i = '0;
    logic [3:0]  req_ready_o;
    logic        unit_valid_o;
    logic [15:0] unit_data_o;
    logic        unit_done_i = 1'b0;
    logic [15:0] unit_data_i = '0;
    logic [3:0]  resp_valid_o;
    logic [15:0] resp_data_o;
    logic        resp_ready_i = 1'b0;
    logic        busy_o;
    logic        err_o;

    flog_arb #(
        .N_REQ   (4),
        .TMO_CYC (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid_i),
        .req_data_i   (req_data_i),
        .req_ready_o  (req_ready_o),
        .unit_valid_o (unit_valid_o),
        .unit_data_o  (unit_data_o),
        .unit_done_i  (unit_done_i),
        .unit_data_i  (unit_data_i),
        .resp_valid_o (resp_valid_o),
        .resp_data_o  (resp_data_o),
        .resp_ready_i (resp_ready_i),
        .busy_o       (busy_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [3:0]  oh;
        logic [15:0] data;
        logic        err;
    } exp_t;

    typedef struct {
        logic [3:0]  vld;
        int          dly;
        logic [15:0] res;
        int          exp_g;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] opv(input int k, input int t);
        return 16'(32'h4000 + k * 256 + t);
    endfunction

    task automatic set_ops(input int t);
        for (int k = 0; k < 4; k++) req_data_i[16*k +: 16] = opv(k, t);
    endtask

    // Pop the expected response when the DUT presents one
    task automatic sb_pop_cmp;
        exp_t e;
        if (resp_valid_o == 4'b0 || sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL resp_missing: got resp_valid=%b with %0d queued, required a response",
                     resp_valid_o, sb.size());
        end else begin
            e = sb.pop_front();
            chk("resp_valid", 32'(resp_valid_o), 32'(e.oh));
            chk("resp_data", 32'(resp_data_o), 32'(e.data));
            chk("resp_err", 32'(err_o), 32'(e.err));
        end
    endtask

    // One complete transaction starting in an IDLE cycle; done arrives in cycle dly,
    // a stray done is always driven in ISSUE, and resp_ready is held low for hold cycles
    task automatic txn(input logic [3:0] vld, input int dly, input logic [15:0] res,
                       input int exp_g, input int hold, input logic [15:0] exp_op);
        logic [3:0] oh;
        oh = 4'(1 << exp_g);
        req_valid_i  = vld;
        resp_ready_i = 1'b0;
        unit_done_i  = 1'b0;
        #1;
        chk("grant", 32'(req_ready_o), 32'(oh));
        chk("idle_busy", 32'(busy_o), 0);
        sb.push_back('{oh, res, 1'b0});
        tick;
        for (int c = 1; c <= dly; c++) begin
            unit_done_i = (c == 1) || (c == dly);
            unit_data_i = (c == dly) ? res : 16'hDEAD;
            #1;
            chk("no_ready", 32'(req_ready_o), 0);
            chk("unit_valid", 32'(unit_valid_o), 32'(c == 1));
            chk("unit_data", 32'(unit_data_o), 32'(exp_op));
            chk("no_resp", 32'(resp_valid_o), 0);
            tick;
        end
        for (int h = 0; h <= hold; h++) begin
            resp_ready_i = (h == hold);
            unit_done_i  = (h == 0 && hold > 0);
            unit_data_i  = 16'hBAD0;
            #1;
            if (h == 0) begin
                sb_pop_cmp();
            end else begin
                chk("hold_valid", 32'(resp_valid_o), 32'(oh));
                chk("hold_data", 32'(resp_data_o), 32'(res));
            end
            chk("resp_no_ready", 32'(req_ready_o), 0);
            tick;
        end
        resp_ready_i = 1'b0;
        unit_done_i  = 1'b0;
        req_valid_i  = '0;
        #1;
        chk("back_idle", 32'(busy_o), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{4'hF,    2, 16'h3F01, 0};
        tbl[1] = '{4'hF,    2, 16'h3F02, 1};
        tbl[2] = '{4'hF,    2, 16'h3F03, 2};
        tbl[3] = '{4'hF,    2, 16'h3F04, 3};
        tbl[4] = '{4'hF,    2, 16'h3F05, 0};
        tbl[5] = '{4'b0001, 3, 16'hBF06, 0};
        tbl[6] = '{4'b1010, 4, 16'h4007, 1};
        tbl[7] = '{4'b1010, 2, 16'hC008, 3};
        tbl[8] = '{4'b0110, 5, 16'h0009, 1};
        tbl[9] = '{4'b1001, 2, 16'h7F80, 3};

        // Reset state with requests pending
        #3 rst = 1'b0;
        req_valid_i = 4'hF;
        set_ops(0);
        #1;
        chk("rst_ready", 32'(req_ready_o), 0);
        chk("rst_unit_valid", 32'(unit_valid_o), 0);
        chk("rst_unit_data", 32'(unit_data_o), 0);
        chk("rst_resp_valid", 32'(resp_valid_o), 0);
        chk("rst_resp_data", 32'(resp_data_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_err", 32'(err_o), 0);
        req_valid_i = '0;
        tick;
        tick;
        rst = 1'b1;

        // Table: fairness with all valid, then sparse patterns exercising wrap-around
        for (int i = 0; i < 10; i++) begin
            set_ops(i + 1);
            txn(tbl[i].vld, tbl[i].dly, tbl[i].res, tbl[i].exp_g, 0, opv(tbl[i].exp_g, i + 1));
        end

        // Single request on lane 2, done at cycle 5, response at cycle 6
        req_data_i = {16'h1111, 16'h4000, 16'h2222, 16'h3333};
        txn(4'b0100, 5, 16'h3F31, 2, 0, 16'h4000);

        // Stray done in IDLE leaves state and result untouched
        unit_done_i = 1'b1;
        unit_data_i = 16'hBEEF;
        #1;
        chk("stray_idle_busy", 32'(busy_o), 0);
        tick;
        unit_done_i = 1'b0;
        #1;
        chk("stray_idle_busy2", 32'(busy_o), 0);
        chk("stray_idle_uv", 32'(unit_valid_o), 0);
        chk("stray_idle_resp", 32'(resp_valid_o), 0);
        chk("stray_idle_data", 32'(resp_data_o), 32'h3F31);

        // Backpressure for 10 cycles with a stray done in RESP
        set_ops(30);
        txn(4'hF, 2, 16'h3F00, 3, 10, opv(3, 30));

        // Done at the would-be expiry cycle (8 WAIT cycles)
        set_ops(31);
        txn(4'b0010, 9, 16'h4111, 1, 0, opv(1, 31));

`ifdef FLOG_ARB_WDOG_EN
        // Watchdog expiry after 8 WAIT cycles
        set_ops(40);
        req_valid_i = 4'b0010;
        #1;
        chk("wd_grant", 32'(req_ready_o), 32'h2);
        sb.push_back('{4'b0010, 16'h7FC0, 1'b1});
        tick;
        for (int c = 1; c <= 9; c++) begin
            unit_done_i = 1'b0;
            #1;
            chk("wd_wait_resp", 32'(resp_valid_o), 0);
            chk("wd_wait_err", 32'(err_o), 0);
            tick;
        end
        sb_pop_cmp();
        resp_ready_i = 1'b1;
        tick;
        resp_ready_i = 1'b0;
        req_valid_i  = '0;
        #1;
        chk("wd_idle", 32'(busy_o), 0);
        chk("wd_err_clear", 32'(err_o), 0);
`else
        // Without the watchdog WAIT persists well past TMO_CYC
        set_ops(41);
        txn(4'b0010, 30, 16'h4222, 1, 0, opv(1, 41));
`endif

        // Reset in WAIT, late done after release is ignored
        set_ops(50);
        req_valid_i = 4'b0100;
        #1;
        chk("rw_grant", 32'(req_ready_o), 32'h4);
        tick;
        #1;
        chk("rw_issue", 32'(unit_valid_o), 1);
        tick;
        tick;
        #1;
        chk("rw_busy", 32'(busy_o), 1);
        #1 rst = 1'b0;
        #1;
        chk("rw_ready", 32'(req_ready_o), 0);
        chk("rw_uv", 32'(unit_valid_o), 0);
        chk("rw_ud", 32'(unit_data_o), 0);
        chk("rw_rv", 32'(resp_valid_o), 0);
        chk("rw_rd", 32'(resp_data_o), 0);
        chk("rw_busy0", 32'(busy_o), 0);
        chk("rw_err", 32'(err_o), 0);
        tick;
        rst = 1'b1;
        req_valid_i = '0;
        unit_done_i = 1'b1;
        unit_data_i = 16'h1234;
        #1;
        chk("late_rv", 32'(resp_valid_o), 0);
        chk("late_busy", 32'(busy_o), 0);
        tick;
        unit_done_i = 1'b0;
        #1;
        chk("late_rv2", 32'(resp_valid_o), 0);
        chk("late_rd", 32'(resp_data_o), 0);
        chk("late_busy2", 32'(busy_o), 0);
        set_ops(51);
        txn(4'hF, 3, 16'h3E00, 0, 0, opv(0, 51));

        chk("sb_empty", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
